// File: rtl/cmp_pkg.sv
// Shared definitions for the DataCompare8 magnitude comparator and the
// window peak tracker built on top of it.
package cmp_pkg;

   // Bit positions inside the 3-bit comparator result; exactly one is set.
   localparam int CMP_GT = 2;
   localparam int CMP_EQ = 1;
   localparam int CMP_LT = 0;

   // Peak tracker control states.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      TRACK = 2'd1,
      DONE  = 2'd2
   } peak_state_t;

endpackage

// File: rtl/DataCompare8.sv
// Unsigned 8-bit magnitude comparator: o[CMP_GT] = a>b, o[CMP_EQ] = a==b,
// o[CMP_LT] = a<b. Purely combinational.
module DataCompare8
   import cmp_pkg::*;
(
   input  logic [7:0] a,
   input  logic [7:0] b,
   output logic [2:0] o
);

   // One-hot relation of a against b.
   always_comb begin
      o         = '0;
      o[CMP_GT] = (a > b);
      o[CMP_EQ] = (a == b);
      o[CMP_LT] = (a < b);
   end

endmodule

// File: rtl/window_peak8.sv
// Window peak tracker: collects N unsigned samples and reports the max and
// min together with the index of the first occurrence of each. Results are
// held after the window completes until the next start.
//
// Handshake: a sample is taken on a rising edge where the block is in TRACK,
// din_valid is high and start is low. din_valid low in TRACK stalls;
// din_valid outside TRACK (or together with start) is dropped. start is a
// one-cycle pulse honoured in every state and always opens an empty window.
module window_peak8
   import cmp_pkg::*;
#(
   parameter int N = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic [7:0]             din,
   input  logic                   din_valid,
   output logic                   busy,
   output logic                   done,
   output logic [7:0]             max_out,
   output logic [7:0]             min_out,
   output logic [$clog2(N)-1:0]   max_idx,
   output logic [$clog2(N)-1:0]   min_idx,
   output logic [$clog2(N+1)-1:0] cnt
);

   localparam int IW = $clog2(N);
   localparam int CW = $clog2(N+1);

   // Current control state; kept as a named signal so checkers can bind to it.
   peak_state_t state;

   logic [2:0] cmp_max_o;
   logic [2:0] cmp_min_o;
   logic       accept;
   logic       last_sample;
   logic       cmp_unused;

   // Sample against the running max and against the running min.
   DataCompare8 u_cmp_max (
      .a (din),
      .b (max_out),
      .o (cmp_max_o)
   );

   DataCompare8 u_cmp_min (
      .a (din),
      .b (min_out),
      .o (cmp_min_o)
   );

   // Only strict greater/less matter; ties keep the earlier index.
   assign cmp_unused  = ^{cmp_max_o[CMP_EQ], cmp_max_o[CMP_LT],
                          cmp_min_o[CMP_GT], cmp_min_o[CMP_EQ]};

   assign accept      = (state == TRACK) && din_valid && !start;
   assign last_sample = (cnt == CW'(N - 1));
   assign busy        = (state == TRACK);

   // FSM, sample counter and result registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         done    <= 1'b0;
         cnt     <= '0;
         max_out <= '0;
         min_out <= '0;
         max_idx <= '0;
         min_idx <= '0;
      end else begin
         done <= 1'b0;
         if (start) begin
            state   <= TRACK;
            cnt     <= '0;
            max_out <= '0;
            min_out <= '0;
            max_idx <= '0;
            min_idx <= '0;
         end else if (accept) begin
            cnt <= cnt + CW'(1);
            if (cnt == '0) begin
               // First sample seeds both extremes.
               max_out <= din;
               min_out <= din;
               max_idx <= '0;
               min_idx <= '0;
            end else begin
               if (cmp_max_o[CMP_GT]) begin
                  max_out <= din;
                  max_idx <= cnt[IW-1:0];
               end
               if (cmp_min_o[CMP_LT]) begin
                  min_out <= din;
                  min_idx <= cnt[IW-1:0];
               end
            end
            if (last_sample) begin
               state <= DONE;
               done  <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_window_peak8.sv
// Bench for window_peak8 with N=4: table-driven windows, hand-written
// stall/restart/reset/DONE-restart sequences and random windows, with a
// queue of expected results compared whenever done pulses.
module tb_window_peak8;

   localparam int N  = 4;
   localparam int IW = $clog2(N);
   localparam int CW = $clog2(N+1);
   localparam int W  = 8 + IW + 8 + IW + CW;

   logic          clk;
   logic          rst_n;
   logic          start;
   logic [7:0]    din;
   logic          din_valid;
   logic          busy;
   logic          done;
   logic [7:0]    max_out;
   logic [7:0]    min_out;
   logic [IW-1:0] max_idx;
   logic [IW-1:0] min_idx;
   logic [CW-1:0] cnt;

   int total;
   int bad;
   int done_seen;
   int done_exp;

   logic [W-1:0] exp_q[$];

   typedef struct {
      logic [7:0]    s [4];
      logic [7:0]    mx;
      logic [IW-1:0] mx_i;
      logic [7:0]    mn;
      logic [IW-1:0] mn_i;
   } vec_t;

   vec_t vecs[6];

   window_peak8 #(.N(N)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .din       (din),
      .din_valid (din_valid),
      .busy      (busy),
      .done      (done),
      .max_out   (max_out),
      .min_out   (min_out),
      .max_idx   (max_idx),
      .min_idx   (min_idx),
      .cnt       (cnt)
   );

   // Clock and reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic send(input logic [7:0] v);
      din       = v;
      din_valid = 1'b1;
      tick();
      din_valid = 1'b0;
   endtask

   task automatic push_exp(input logic [7:0] mx, input logic [IW-1:0] mxi,
                           input logic [7:0] mn, input logic [IW-1:0] mni);
      exp_q.push_back({mx, mxi, mn, mni, CW'(N)});
      done_exp++;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_done"}, 32'(done), 32'd0);
      check({tag, "_max"},  32'(max_out), 32'd0);
      check({tag, "_min"},  32'(min_out), 32'd0);
      check({tag, "_maxi"}, 32'(max_idx), 32'd0);
      check({tag, "_mini"}, 32'(min_idx), 32'd0);
      check({tag, "_cnt"},  32'(cnt), 32'd0);
   endtask

   // Scoreboard: compare the held result whenever done pulses.
   always @(negedge clk) begin
      if (rst_n && done) begin
         done_seen++;
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_done: got result %0h want no done", {max_out, max_idx, min_out, min_idx, cnt});
         end else begin
            check("window_result", 32'({max_out, max_idx, min_out, min_idx, cnt}), 32'(exp_q.pop_front()));
         end
      end
   end

   initial begin
      logic [7:0]    rs [4];
      logic [7:0]    mx, mn;
      logic [IW-1:0] mxi, mni;

      total = 0; bad = 0; done_seen = 0; done_exp = 0;
      start = 1'b0; din = '0; din_valid = 1'b0; rst_n = 1'b0;

      vecs[0] = '{s: '{8'h05, 8'h80, 8'h02, 8'h80}, mx: 8'h80, mx_i: 2'd1, mn: 8'h02, mn_i: 2'd2};
      vecs[1] = '{s: '{8'hF0, 8'hF0, 8'hF0, 8'hF0}, mx: 8'hF0, mx_i: 2'd0, mn: 8'hF0, mn_i: 2'd0};
      vecs[2] = '{s: '{8'h11, 8'h22, 8'h33, 8'h44}, mx: 8'h44, mx_i: 2'd3, mn: 8'h11, mn_i: 2'd0};
      vecs[3] = '{s: '{8'h44, 8'h33, 8'h22, 8'h11}, mx: 8'h44, mx_i: 2'd0, mn: 8'h11, mn_i: 2'd3};
      vecs[4] = '{s: '{8'h00, 8'hFF, 8'h00, 8'hFF}, mx: 8'hFF, mx_i: 2'd1, mn: 8'h00, mn_i: 2'd0};
      vecs[5] = '{s: '{8'h07, 8'h03, 8'h09, 8'h03}, mx: 8'h09, mx_i: 2'd2, mn: 8'h03, mn_i: 2'd1};

      // Reset state
      repeat (3) tick();
      check_all_zero("reset");
      rst_n = 1'b1;
      tick();
      send(8'h42);
      check_all_zero("idle_ignore");

      // Table-driven windows, back-to-back samples
      for (int v = 0; v < 6; v++) begin
         push_exp(vecs[v].mx, vecs[v].mx_i, vecs[v].mn, vecs[v].mn_i);
         pulse_start();
         check("start_busy", 32'(busy), 32'd1);
         check("start_cnt", 32'(cnt), 32'd0);
         for (int k = 0; k < 4; k++) send(vecs[v].s[k]);
         check("done_pulse", 32'(done), 32'd1);
         check("busy_at_done", 32'(busy), 32'd0);
         tick();
         check("done_low_after", 32'(done), 32'd0);
      end

      // Stall in the middle of a window
      push_exp(8'hFF, 2'd2, 8'h00, 2'd1);
      pulse_start();
      send(8'h10);
      send(8'h00);
      repeat (3) tick();
      check("stall_cnt", 32'(cnt), 32'd2);
      check("stall_busy", 32'(busy), 32'd1);
      check("stall_done", 32'(done), 32'd0);
      send(8'hFF);
      send(8'h01);
      check("stall_done_pulse", 32'(done), 32'd1);

      // Restart mid-window, including a sample that arrives with start
      push_exp(8'h44, 2'd3, 8'h11, 2'd0);
      pulse_start();
      send(8'hAA);
      send(8'hBB);
      check("pre_restart_cnt", 32'(cnt), 32'd2);
      start = 1'b1; din = 8'h99; din_valid = 1'b1;
      tick();
      start = 1'b0; din_valid = 1'b0;
      check("restart_cnt", 32'(cnt), 32'd0);
      check("restart_max", 32'(max_out), 32'd0);
      check("restart_busy", 32'(busy), 32'd1);
      send(8'h11); send(8'h22); send(8'h33); send(8'h44);
      check("restart_done", 32'(done), 32'd1);

      // Reset mid-window
      pulse_start();
      send(8'h50); send(8'h60); send(8'h70);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check_all_zero("midreset");
      send(8'h55); send(8'h66);
      check_all_zero("post_reset_ignore");

      // DONE holds, then start together with din_valid opens an empty window
      push_exp(8'hC0, 2'd0, 8'h01, 2'd3);
      pulse_start();
      send(8'hC0); send(8'h20); send(8'h30); send(8'h01);
      repeat (3) tick();
      check("hold_max", 32'(max_out), 32'hC0);
      check("hold_min", 32'(min_out), 32'h01);
      check("hold_cnt", 32'(cnt), 32'd4);
      check("hold_done", 32'(done), 32'd0);
      check("hold_busy", 32'(busy), 32'd0);
      start = 1'b1; din = 8'hEE; din_valid = 1'b1;
      tick();
      start = 1'b0; din_valid = 1'b0;
      check("done_restart_cnt", 32'(cnt), 32'd0);
      check("done_restart_max", 32'(max_out), 32'd0);
      check("done_restart_busy", 32'(busy), 32'd1);
      push_exp(8'h90, 2'd2, 8'h05, 2'd1);
      send(8'h30); send(8'h05); send(8'h90); send(8'h05);
      check("done_restart_done", 32'(done), 32'd1);

      // Random windows with random stalls; narrow ranges create ties
      for (int r = 0; r < 16; r++) begin
         for (int k = 0; k < 4; k++)
            rs[k] = (r % 2 == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 3));
         mx = rs[0]; mn = rs[0]; mxi = '0; mni = '0;
         for (int k = 1; k < 4; k++) begin
            if (rs[k] > mx) begin mx = rs[k]; mxi = IW'(k); end
            if (rs[k] < mn) begin mn = rs[k]; mni = IW'(k); end
         end
         push_exp(mx, mxi, mn, mni);
         pulse_start();
         for (int k = 0; k < 4; k++) begin
            repeat ($urandom_range(0, 2)) tick();
            send(rs[k]);
         end
         check("rand_done", 32'(done), 32'd1);
      end

      repeat (3) tick();
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      check("done_count", 32'(done_seen), 32'(done_exp));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
